// File: rtl/hazard_pkg.sv
// Shared types and constants for the forwarding / load-use hazard unit.
// Stage info carries a destination index wide enough for any supported REG_AW.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // rd is zero-extended into this width so the struct is independent of REG_AW (REG_AW <= 8).
  localparam int STAGE_RD_W = 8;

  typedef struct packed {
    logic                  valid;
    logic [STAGE_RD_W-1:0] rd;
    logic                  regwrite;
    logic                  is_load;
  } stage_info_t;

endpackage

// File: rtl/fwd_src_match.sv
// Compares one source operand against a younger (near) and an older (far) producer stage.
// Yields a forward select plus per-stage load-match flags for the hazard logic.
module fwd_src_match
  import hazard_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter bit FAR_LOAD_FWD = 1'b1
) (
  input  logic [REG_AW-1:0] src,
  input  logic              src_used,
  input  logic              src_valid,
  input  stage_info_t       near_info,
  input  stage_info_t       far_info,
  output logic [1:0]        sel,
  output logic              near_load_match,
  output logic              far_load_match
);

  logic [STAGE_RD_W-1:0] src_ext_s;
  logic                  enable_s;
  logic                  near_hit_s;
  logic                  far_hit_s;

  assign src_ext_s = STAGE_RD_W'(src);

  // Producer matching and select priority: the younger producer always wins.
  always_comb begin
    enable_s        = src_valid && src_used && (src != '0);
    near_hit_s      = enable_s && near_info.valid && near_info.regwrite &&
                      (near_info.rd == src_ext_s);
    far_hit_s       = enable_s && far_info.valid && far_info.regwrite &&
                      (far_info.rd == src_ext_s);
    near_load_match = near_hit_s && near_info.is_load;
    far_load_match  = far_hit_s && far_info.is_load;
    sel             = FWD_RF;
    if (near_hit_s) begin
      sel = FWD_MEM;
    end else if (far_hit_s && (FAR_LOAD_FWD || !far_info.is_load)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall generator for a 5-stage RISC-V pipeline.
// Tracks its own EX/MEM/WB shadow of destination info and counts stall cycles.
module fwd_hazard_unit
  import hazard_pkg::*;
#(
  parameter int NUM_SRC  = 2,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_regwrite,
  input  logic                      id_is_load,
  input  logic                      ext_stall,
  input  logic                      flush,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      stall_id,
  output logic                      bubble_ex,
  output logic [CNT_W-1:0]          stall_cnt
);

  stage_info_t               id_info_s;
  stage_info_t               ex_info_r;
  stage_info_t               mem_info_r;
  stage_info_t               wb_info_r;
  logic [NUM_SRC*REG_AW-1:0] ex_rs_r;
  logic [NUM_SRC-1:0]        ex_rs_used_r;
  logic [NUM_SRC-1:0]        ex_near_load_s;
  logic [NUM_SRC-1:0]        ex_far_load_s;
  logic [NUM_SRC-1:0]        id_near_load_s;
  logic [NUM_SRC-1:0]        id_far_load_s;
  logic [NUM_SRC*2-1:0]      id_sel_s;
  logic                      hazard_s;
  logic                      unused_s;

  // Pack the ID instruction into the common stage format.
  always_comb begin
    id_info_s          = '0;
    id_info_s.valid    = id_valid;
    id_info_s.rd       = STAGE_RD_W'(id_rd);
    id_info_s.regwrite = id_regwrite;
    id_info_s.is_load  = id_is_load;
  end

  // EX sources look at MEM/WB for forwarding; ID sources look at EX/MEM for load-use.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_match #(
      .REG_AW      (REG_AW),
      .FAR_LOAD_FWD(LOAD_LAT == 1)
    ) u_ex_match (
      .src            (ex_rs_r[i*REG_AW +: REG_AW]),
      .src_used       (ex_rs_used_r[i]),
      .src_valid      (ex_info_r.valid),
      .near_info      (mem_info_r),
      .far_info       (wb_info_r),
      .sel            (fwd_sel[i*2 +: 2]),
      .near_load_match(ex_near_load_s[i]),
      .far_load_match (ex_far_load_s[i])
    );

    fwd_src_match #(
      .REG_AW      (REG_AW),
      .FAR_LOAD_FWD(1'b1)
    ) u_id_match (
      .src            (id_rs[i*REG_AW +: REG_AW]),
      .src_used       (id_rs_used[i]),
      .src_valid      (id_valid),
      .near_info      (ex_info_r),
      .far_info       (mem_info_r),
      .sel            (id_sel_s[i*2 +: 2]),
      .near_load_match(id_near_load_s[i]),
      .far_load_match (id_far_load_s[i])
    );
  end

  // A load still in MEM only blocks the consumer when load data skips the WB bypass.
  always_comb begin
    hazard_s = 1'b0;
    if (LOAD_LAT >= 2) begin
      hazard_s = (|id_near_load_s) || (|id_far_load_s);
    end else begin
      hazard_s = |id_near_load_s;
    end
    stall_id  = hazard_s && !flush;
    bubble_ex = stall_id || flush;
  end

  assign unused_s = ^{ex_near_load_s, ex_far_load_s, id_sel_s};

  // Shadow pipeline: freeze beats everything, otherwise advance with an optional EX bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_info_r    <= '0;
      mem_info_r   <= '0;
      wb_info_r    <= '0;
      ex_rs_r      <= '0;
      ex_rs_used_r <= '0;
    end else if (ext_stall) begin
      ex_info_r    <= ex_info_r;
      mem_info_r   <= mem_info_r;
      wb_info_r    <= wb_info_r;
      ex_rs_r      <= ex_rs_r;
      ex_rs_used_r <= ex_rs_used_r;
    end else begin
      mem_info_r <= ex_info_r;
      wb_info_r  <= mem_info_r;
      if (bubble_ex) begin
        ex_info_r    <= '0;
        ex_rs_r      <= '0;
        ex_rs_used_r <= '0;
      end else begin
        ex_info_r    <= id_info_s;
        ex_rs_r      <= id_rs;
        ex_rs_used_r <= id_rs_used;
      end
    end
  end

  // Saturating count of load-use stall cycles that actually take effect.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_id && !ext_stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: dut_a uses LOAD_LAT=1, dut_b uses LOAD_LAT=2 with a 2-bit counter
// so saturation is reachable. Only the selected DUT sees live stimulus.
module tb_fwd_hazard_unit;

  localparam int NS = 2;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          sel_b;
  logic          d_valid;
  logic [NS*AW-1:0] d_rs;
  logic [NS-1:0] d_used;
  logic [AW-1:0] d_rd;
  logic          d_rw;
  logic          d_ld;
  logic          d_xs;
  logic          d_fl;

  logic [3:0]  a_fwd, b_fwd, o_fwd;
  logic        a_stall, b_stall, o_stall;
  logic        a_bub, b_bub, o_bub;
  logic [15:0] a_cnt, o_cnt;
  logic [1:0]  b_cnt;

  int checks = 0;
  int errors = 0;

  fwd_hazard_unit #(.NUM_SRC(NS), .REG_AW(AW), .LOAD_LAT(1), .CNT_W(16)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (d_valid & ~sel_b),
    .id_rs      (sel_b ? '0 : d_rs),
    .id_rs_used (sel_b ? '0 : d_used),
    .id_rd      (sel_b ? '0 : d_rd),
    .id_regwrite(d_rw & ~sel_b),
    .id_is_load (d_ld & ~sel_b),
    .ext_stall  (d_xs & ~sel_b),
    .flush      (d_fl & ~sel_b),
    .fwd_sel    (a_fwd),
    .stall_id   (a_stall),
    .bubble_ex  (a_bub),
    .stall_cnt  (a_cnt)
  );

  fwd_hazard_unit #(.NUM_SRC(NS), .REG_AW(AW), .LOAD_LAT(2), .CNT_W(2)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (d_valid & sel_b),
    .id_rs      (sel_b ? d_rs : '0),
    .id_rs_used (sel_b ? d_used : '0),
    .id_rd      (sel_b ? d_rd : '0),
    .id_regwrite(d_rw & sel_b),
    .id_is_load (d_ld & sel_b),
    .ext_stall  (d_xs & sel_b),
    .flush      (d_fl & sel_b),
    .fwd_sel    (b_fwd),
    .stall_id   (b_stall),
    .bubble_ex  (b_bub),
    .stall_cnt  (b_cnt)
  );

  assign o_fwd   = sel_b ? b_fwd : a_fwd;
  assign o_stall = sel_b ? b_stall : a_stall;
  assign o_bub   = sel_b ? b_bub : a_bub;
  assign o_cnt   = sel_b ? {14'd0, b_cnt} : a_cnt;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fwd(input string tag, input logic [3:0] exp);
    chk(tag, {12'd0, o_fwd}, {12'd0, exp});
  endtask

  task automatic chk_st(input string tag, input logic exp_stall, input logic exp_bub);
    chk(tag, {14'd0, o_stall, o_bub}, {14'd0, exp_stall, exp_bub});
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] exp);
    chk(tag, o_cnt, exp);
  endtask

  task automatic instr(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [1:0] u, input logic [4:0] rd, input logic rw, input logic ld);
    d_valid = v;
    d_rs    = {r1, r0};
    d_used  = u;
    d_rd    = rd;
    d_rw    = rw;
    d_ld    = ld;
  endtask

  task automatic nop();
    instr(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic alu(input logic [4:0] rd, input logic [4:0] r0, input logic [4:0] r1,
                     input logic [1:0] u);
    instr(1'b1, r0, r1, u, rd, 1'b1, 1'b0);
  endtask

  task automatic lw(input logic [4:0] rd);
    instr(1'b1, 5'd1, 5'd0, 2'b01, rd, 1'b1, 1'b1);
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    nop();
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin
    reset = 1'b1;
    sel_b = 1'b0;
    d_xs  = 1'b0;
    d_fl  = 1'b0;
    nop();
    cyc();
    cyc();
    chk_fwd("reset_fwd", 4'b0000);
    chk_st("reset_stall", 1'b0, 1'b0);
    chk_cnt("reset_cnt", 16'd0);
    reset = 1'b0;
    cyc();

    // add x5 ; sub x6,x5,x7
    alu(5'd5, 5'd1, 5'd2, 2'b11); #1;
    chk_st("t1_add_id", 1'b0, 1'b0);
    cyc();
    alu(5'd6, 5'd5, 5'd7, 2'b11); #1;
    chk_st("t1_alu_no_stall", 1'b0, 1'b0);
    cyc();
    nop(); #1;
    chk_fwd("t1_mem_fwd", 4'b0010);
    drain(3);

    // add x5 ; nop ; or x8,x5,x5
    alu(5'd5, 5'd1, 5'd2, 2'b11); cyc();
    nop(); cyc();
    alu(5'd8, 5'd5, 5'd5, 2'b11); cyc();
    nop(); #1;
    chk_fwd("t2_wb_both", 4'b0101);
    drain(3);

    // add x5 ; addi x5,x0 ; add x9,x5,x0
    alu(5'd5, 5'd1, 5'd2, 2'b11); cyc();
    alu(5'd5, 5'd0, 5'd0, 2'b01); cyc();
    alu(5'd9, 5'd5, 5'd0, 2'b11); #1;
    chk_st("t2_no_stall", 1'b0, 1'b0);
    cyc();
    nop(); #1;
    chk_fwd("t2_mem_beats_wb", 4'b0010);
    drain(3);

    // Load-use, one bubble
    lw(5'd5); cyc();
    alu(5'd6, 5'd5, 5'd0, 2'b11); #1;
    chk_st("t3_stall", 1'b1, 1'b1);
    chk_cnt("t3_cnt_before", 16'd0);
    cyc();
    chk_st("t3_released", 1'b0, 1'b0);
    cyc();
    nop(); #1;
    chk_fwd("t3_wb_fwd", 4'b0001);
    chk_cnt("t3_cnt", 16'd1);
    drain(3);

    // lw x0 ; consumer of x0
    instr(1'b1, 5'd1, 5'd0, 2'b01, 5'd0, 1'b1, 1'b1); cyc();
    alu(5'd6, 5'd0, 5'd0, 2'b11); #1;
    chk_st("t4_x0_no_stall", 1'b0, 1'b0);
    cyc();
    nop(); #1;
    chk_fwd("t4_x0_fwd", 4'b0000);
    drain(3);
    // lw x5 ; instruction reading nothing
    lw(5'd5); cyc();
    alu(5'd6, 5'd5, 5'd5, 2'b00); #1;
    chk_st("t4_unused_no_stall", 1'b0, 1'b0);
    cyc();
    nop(); #1;
    chk_fwd("t4_unused_fwd", 4'b0000);
    chk_cnt("t4_cnt", 16'd1);
    drain(3);

    // Load-use under a 3-cycle freeze
    lw(5'd5); cyc();
    alu(5'd6, 5'd5, 5'd0, 2'b11);
    d_xs = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk_st("t5_frozen_stall", 1'b1, 1'b1);
      chk_cnt("t5_frozen_cnt", 16'd1);
      cyc();
    end
    d_xs = 1'b0; #1;
    chk_st("t5_after_release", 1'b1, 1'b1);
    cyc();
    chk_st("t5_released", 1'b0, 1'b0);
    cyc();
    nop(); #1;
    chk_fwd("t5_wb_fwd", 4'b0001);
    chk_cnt("t5_cnt", 16'd2);
    drain(3);

    // Flush wins over a pending hazard
    lw(5'd5); cyc();
    alu(5'd6, 5'd5, 5'd0, 2'b11);
    d_fl = 1'b1; #1;
    chk_st("t6_flush", 1'b0, 1'b1);
    cyc();
    d_fl = 1'b0;
    nop(); #1;
    chk_fwd("t6_ex_killed", 4'b0000);
    chk_cnt("t6_cnt", 16'd2);
    drain(3);

    // Reset in the middle of a stall
    lw(5'd5); cyc();
    alu(5'd6, 5'd5, 5'd0, 2'b11); #1;
    chk_st("t6_pre_reset_stall", 1'b1, 1'b1);
    reset = 1'b1;
    cyc();
    reset = 1'b0; #1;
    chk_st("t6_post_reset", 1'b0, 1'b0);
    chk_fwd("t6_post_reset_fwd", 4'b0000);
    chk_cnt("t6_post_reset_cnt", 16'd0);
    drain(3);

    // LOAD_LAT=2 instance: two bubbles, regfile path afterwards, saturating counter
    sel_b = 1'b1;
    drain(2);
    lw(5'd5); cyc();
    alu(5'd6, 5'd5, 5'd0, 2'b11); #1;
    chk_st("l2_stall1", 1'b1, 1'b1);
    cyc();
    chk_st("l2_stall2", 1'b1, 1'b1);
    cyc();
    chk_st("l2_released", 1'b0, 1'b0);
    cyc();
    nop(); #1;
    chk_fwd("l2_no_wb_load_fwd", 4'b0000);
    chk_cnt("l2_cnt", 16'd2);
    drain(3);

    lw(5'd5); cyc();
    alu(5'd6, 5'd5, 5'd0, 2'b11); cyc();
    cyc();
    cyc();
    nop(); #1;
    chk_cnt("l2_cnt_sat", 16'd3);
    drain(3);

    lw(5'd5); cyc();
    alu(5'd6, 5'd5, 5'd0, 2'b11); #1;
    chk_st("l2_sat_stall", 1'b1, 1'b1);
    cyc();
    cyc();
    cyc();
    nop(); #1;
    chk_cnt("l2_cnt_hold", 16'd3);
    drain(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
